// File: rtl/perf_pkg.sv
// Shared definitions for the perf read bus: widths, address type and the
// per-channel offset helpers used by every perf agent's readout decoder.
package perf_pkg;

  localparam int PERF_ADDR_W = 8;
  localparam int PERF_DATA_W = 32;

  typedef logic [PERF_ADDR_W-1:0] perf_addr_t;
  typedef logic [PERF_DATA_W-1:0] perf_data_t;

  // Low 32 bits of channel n live at an even offset.
  function automatic int perf_lo_off(input int n);
    return 2 * n;
  endfunction

  // Upper bits of channel n sit directly after its low word.
  function automatic int perf_hi_off(input int n);
    return 2 * n + 1;
  endfunction

  // Status word follows the last channel's hi word.
  function automatic int perf_status_off(input int num_ch);
    return 2 * num_ch;
  endfunction

endpackage

// File: rtl/perf_if.sv
// Perf read bus. Handshake: the master presents addr with stb high for one
// cycle per read (stb held k cycles means k reads); the addressed slave
// answers with ack and data in the following cycle only. There is no
// back-pressure: stall is always 0 from this slave.
interface perf_if;
  import perf_pkg::*;

  perf_addr_t addr;
  logic       stb;
  perf_data_t data;
  logic       ack;
  logic       stall;

  modport master (output addr, output stb, input data, input ack, input stall);
  modport slave  (input addr, input stb, output data, output ack, output stall);

endinterface

// File: rtl/perf_counter_bank_ch.sv
// One performance counter channel: a CNT_W-bit event counter with a sticky
// overflow flag. SATURATE selects hold-at-all-ones versus wrap-to-zero.
// clear has priority over incr.
module perf_counter_bank_ch #(
  parameter int CNT_W    = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             incr,
  input  logic             clear,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  logic [CNT_W-1:0] value_nxt;
  logic             ovf_nxt;

  // Next count and flag: clear first, then increment with overflow policy.
  always_comb begin
    value_nxt = value;
    ovf_nxt   = ovf;
    if (clear) begin
      value_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (incr) begin
      if (&value) begin
        ovf_nxt   = 1'b1;
        value_nxt = SATURATE ? value : '0;
      end else begin
        value_nxt = value + 1'b1;
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      value <= value_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter bank on the perf read bus.
// Window: BASE_ADDR + 2n = counter[n] low word, +2n+1 = upper bits,
// +2*NUM_CH = overflow status. Reads are answered one cycle after stb.
// Optional macro PERF_COUNTER_BANK_SNAPSHOT_EN: reading a low word latches
// that channel's upper bits into a shadow, which the hi read then returns.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter perf_addr_t BASE_ADDR = 8'h00,
  parameter int         NUM_CH    = 4,
  parameter int         CNT_W     = 48,
  parameter bit         SATURATE  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_incr,
  input  logic              i_enable,
  input  logic              i_clear,
  perf_if.slave             perf
);

  if (int'(BASE_ADDR) + 2 * NUM_CH > 255) begin : g_bad_window
    $fatal(1, "perf_counter_bank: address window runs past 8'hFF");
  end

  logic [CNT_W-1:0]  cnt_val [NUM_CH];
  logic [63:0]       cnt_ext [NUM_CH];
  logic [31:0]       hi_word [NUM_CH];
  logic [NUM_CH-1:0] ovf_vec;
  logic [NUM_CH-1:0] lo_hit;

  // A 9-bit difference tells us both the offset and whether addr < BASE_ADDR.
  logic [8:0] diff;
  logic [7:0] off;
  logic       in_window;

  assign diff      = {1'b0, perf.addr} - {1'b0, BASE_ADDR};
  assign off       = diff[7:0];
  assign in_window = ~diff[8];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    perf_counter_bank_ch #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk   (i_clk),
      .reset (i_reset),
      .incr  (i_incr[n] & i_enable),
      .clear (i_clear),
      .value (cnt_val[n]),
      .ovf   (ovf_vec[n])
    );

    assign cnt_ext[n] = 64'(cnt_val[n]);
    assign lo_hit[n]  = perf.stb && in_window && (int'(off) == perf_lo_off(n));

`ifdef PERF_COUNTER_BANK_SNAPSHOT_EN
    logic [31:0] shadow;

    // Latch the upper bits whenever the low word is read, so lo-then-hi is coherent.
    always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
        shadow <= '0;
      end else if (lo_hit[n]) begin
        shadow <= cnt_ext[n][63:32];
      end
    end

    assign hi_word[n] = shadow;
`else
    assign hi_word[n] = cnt_ext[n][63:32];
`endif
  end

  logic        rd_hit;
  logic [31:0] rd_data;

  // Address decode and readout mux over the current (pre-increment) state.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (perf.stb && in_window) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (int'(off) == perf_lo_off(n)) begin
          rd_hit  = 1'b1;
          rd_data = cnt_ext[n][31:0];
        end
        if (int'(off) == perf_hi_off(n)) begin
          rd_hit  = 1'b1;
          rd_data = hi_word[n];
        end
      end
      if (int'(off) == perf_status_off(NUM_CH)) begin
        rd_hit  = 1'b1;
        rd_data = 32'(ovf_vec);
      end
    end
  end

  // Registered response: ack and data appear in the cycle after stb.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      perf.ack  <= 1'b0;
      perf.data <= '0;
    end else begin
      perf.ack  <= rd_hit;
      perf.data <= rd_data;
    end
  end

  assign perf.stall = 1'b0;

endmodule
